// File: rtl/jump_pkg.sv
// Shared types and widths for the jump launch controller and its debouncer.
package jump_pkg;

  localparam int unsigned V_W      = 11;
  localparam int unsigned DIST_W   = 11;
  localparam int unsigned HEIGHT_W = 9;

  localparam int unsigned V_MIN_DEF    = 16;
  localparam int unsigned V_STEP_DEF   = 4;
  localparam int unsigned V_MAX_DEF    = 1023;
  localparam int unsigned DEBOUNCE_DEF = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHARGE,
    ST_LAUNCH,
    ST_FLY,
    ST_LAND
  } jl_state_e;

endpackage

// File: rtl/btn_debounce.sv
// Button debouncer: the level flips after DEBOUNCE consecutive mismatching samples;
// o_rise pulses for one cycle together with the accepted rising level.
module btn_debounce #(
  parameter int unsigned DEBOUNCE = 3
) (
  input  logic clk_jump,
  input  logic rst_n,
  input  logic i_raw,
  output logic o_level,
  output logic o_rise
);

  localparam int unsigned CW = (DEBOUNCE < 2) ? 1 : $clog2(DEBOUNCE);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          rise_q, rise_d;

  // A matching sample restarts the count, so only an unbroken run can flip the level.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    rise_d  = 1'b0;
    if (i_raw != level_q) begin
      if (cnt_q == CW'(DEBOUNCE - 1)) begin
        level_d = i_raw;
        rise_d  = i_raw;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_jump or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
    end
  end

  assign o_level = level_q;
  assign o_rise  = rise_q;

endmodule

// File: rtl/jump_launch_ctrl.sv
// Press-and-hold jump launcher: charges a velocity, launches on release, waits for landing.
// Optional JUMP_CHARGE_PINGPONG_EN makes the charge bounce between V_MIN and V_MAX.
module jump_launch_ctrl
  import jump_pkg::*;
#(
  parameter int unsigned V_MIN    = V_MIN_DEF,
  parameter int unsigned V_STEP   = V_STEP_DEF,
  parameter int unsigned V_MAX    = V_MAX_DEF,
  parameter int unsigned DEBOUNCE = DEBOUNCE_DEF
) (
  input  logic              clk_jump,
  input  logic              rst_n,
  input  logic              i_btn,
  input  logic              i_game_run,
  input  logic              i_done,
  input  logic [DIST_W-1:0] i_dist,
  output logic              o_en,
  output logic [V_W-1:0]    o_v_init,
  output logic [V_W-1:0]    o_charge,
  output logic              o_busy,
  output logic              o_land_valid,
  output logic [DIST_W-1:0] o_land_dist
);

  localparam int unsigned    VX     = V_W + 1;
  localparam logic [VX-1:0]  STEP_X = VX'(V_STEP);
  localparam logic [VX-1:0]  MAX_X  = VX'(V_MAX);
  localparam logic [V_W-1:0] VMIN_C = V_W'(V_MIN);
  localparam logic [V_W-1:0] VMAX_C = V_W'(V_MAX);

  jl_state_e         state_q, state_d;
  logic [V_W-1:0]    charge_q, charge_d, charge_nxt;
  logic [V_W-1:0]    v_init_q, v_init_d;
  logic              en_q, en_d;
  logic              busy_q, busy_d;
  logic              lv_q, lv_d;
  logic [DIST_W-1:0] ldist_q, ldist_d;
  logic [VX-1:0]     sum_up;
  logic              btn_db, btn_rise;

  btn_debounce #(.DEBOUNCE(DEBOUNCE)) u_btn_db (
    .clk_jump (clk_jump),
    .rst_n    (rst_n),
    .i_raw    (i_btn),
    .o_level  (btn_db),
    .o_rise   (btn_rise)
  );

  // One extra bit so the step can overshoot before clamping.
  assign sum_up = {1'b0, charge_q} + STEP_X;

`ifdef JUMP_CHARGE_PINGPONG_EN
  localparam logic [VX-1:0]  MIN_X   = VX'(V_MIN);
  localparam logic [V_W-1:0] VSTEP_C = V_W'(V_STEP);

  logic dir_up_q, dir_up_d, dir_up_nxt;

  always_comb begin
    charge_nxt = charge_q;
    dir_up_nxt = dir_up_q;
    if (dir_up_q) begin
      if (sum_up >= MAX_X) begin
        charge_nxt = VMAX_C;
        dir_up_nxt = 1'b0;
      end else begin
        charge_nxt = sum_up[V_W-1:0];
      end
    end else if ({1'b0, charge_q} < MIN_X + STEP_X) begin
      charge_nxt = VMIN_C;
      dir_up_nxt = 1'b1;
    end else begin
      charge_nxt = charge_q - VSTEP_C;
    end
  end

  always_ff @(posedge clk_jump or negedge rst_n) begin
    if (!rst_n) dir_up_q <= 1'b1;
    else        dir_up_q <= dir_up_d;
  end
`else
  always_comb begin
    charge_nxt = (sum_up >= MAX_X) ? VMAX_C : sum_up[V_W-1:0];
  end
`endif

  always_comb begin
    state_d  = state_q;
    charge_d = charge_q;
    v_init_d = v_init_q;
    en_d     = 1'b0;
    lv_d     = 1'b0;
    ldist_d  = ldist_q;
`ifdef JUMP_CHARGE_PINGPONG_EN
    dir_up_d = dir_up_q;
`endif
    if (!i_game_run) begin
      state_d  = ST_IDLE;
      charge_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (btn_rise) begin
            state_d  = ST_CHARGE;
            charge_d = VMIN_C;
`ifdef JUMP_CHARGE_PINGPONG_EN
            dir_up_d = 1'b1;
`endif
          end
        end
        ST_CHARGE: begin
          if (btn_db) begin
            charge_d = charge_nxt;
`ifdef JUMP_CHARGE_PINGPONG_EN
            dir_up_d = dir_up_nxt;
`endif
          end else begin
            v_init_d = charge_q;
            state_d  = ST_LAUNCH;
          end
        end
        // v_init is already stable here; enable follows a cycle later.
        ST_LAUNCH: begin
          en_d    = 1'b1;
          state_d = ST_FLY;
        end
        ST_FLY: begin
          if (i_done) begin
            ldist_d  = i_dist;
            lv_d     = 1'b1;
            charge_d = '0;
            state_d  = ST_LAND;
          end else begin
            en_d = 1'b1;
          end
        end
        ST_LAND: begin
          charge_d = '0;
          if (!i_done && !btn_db) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk_jump or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      charge_q <= '0;
      v_init_q <= '0;
      en_q     <= 1'b0;
      busy_q   <= 1'b0;
      lv_q     <= 1'b0;
      ldist_q  <= '0;
    end else begin
      state_q  <= state_d;
      charge_q <= charge_d;
      v_init_q <= v_init_d;
      en_q     <= en_d;
      busy_q   <= busy_d;
      lv_q     <= lv_d;
      ldist_q  <= ldist_d;
    end
  end

  assign o_en         = en_q;
  assign o_v_init     = v_init_q;
  assign o_charge     = charge_q;
  assign o_busy       = busy_q;
  assign o_land_valid = lv_q;
  assign o_land_dist  = ldist_q;

endmodule

// File: tb/tb_jump_launch_ctrl.sv
// Self-checking bench for jump_launch_ctrl: scenario tasks plus randomized jumps
// checked against an arithmetic model of charge, launch timing and landing capture.
module tb_jump_launch_ctrl;

  localparam int V_MIN  = 16;
  localparam int V_STEP = 4;
  localparam int V_MAX  = 1023;

  logic        clk_jump = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_btn = 1'b0;
  logic        i_game_run = 1'b0;
  logic        i_done = 1'b0;
  logic [10:0] i_dist = '0;
  logic        o_en, o_busy, o_land_valid;
  logic [10:0] o_v_init, o_charge, o_land_dist;

  int          checks = 0;
  int          failures = 0;
  logic [10:0] last_dist = '0;

  jump_launch_ctrl dut (
    .clk_jump     (clk_jump),
    .rst_n        (rst_n),
    .i_btn        (i_btn),
    .i_game_run   (i_game_run),
    .i_done       (i_done),
    .i_dist       (i_dist),
    .o_en         (o_en),
    .o_v_init     (o_v_init),
    .o_charge     (o_charge),
    .o_busy       (o_busy),
    .o_land_valid (o_land_valid),
    .o_land_dist  (o_land_dist)
  );

  always #5 clk_jump = ~clk_jump;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Charge value after n increment cycles, straight from the charging rules.
  function automatic int exp_charge(input int n);
`ifdef JUMP_CHARGE_PINGPONG_EN
    int c = V_MIN;
    bit up = 1'b1;
    for (int i = 0; i < n; i++) begin
      if (up) begin
        c = c + V_STEP;
        if (c >= V_MAX) begin c = V_MAX; up = 1'b0; end
      end else if (c < V_MIN + V_STEP) begin
        c = V_MIN; up = 1'b1;
      end else begin
        c = c - V_STEP;
      end
    end
    return c;
`else
    return (V_MIN + n * V_STEP > V_MAX) ? V_MAX : V_MIN + n * V_STEP;
`endif
  endfunction

  task automatic tick();
    @(posedge clk_jump);
    #1;
  endtask

  // Hold the button for h edges from IDLE; ends in the LAUNCH cycle.
  task automatic charge_phase(input int h, input string tag);
    logic [10:0] want;
    for (int k = 1; k <= h + 3; k++) begin
      i_btn = (k <= h);
      tick();
      checks++;
      if (k >= 4) begin
        want = 11'(exp_charge(k - 4));
        if ({o_busy, o_charge} !== {1'b1, want}) begin
          failures++;
          $display("FAIL %s_charge k=%0d: busy=%0b charge=%0d want busy=1 charge=%0d",
                   tag, k, o_busy, o_charge, want);
        end
      end else if (o_busy !== 1'b0) begin
        failures++;
        $display("FAIL %s_predebounce k=%0d: busy=%0b want 0", tag, k, o_busy);
      end
    end
    tick();
    want = 11'(exp_charge(h - 1));
    checks++;
    if ({o_busy, o_en, o_v_init} !== {1'b1, 1'b0, want}) begin
      failures++;
      $display("FAIL %s_launch: busy=%0b en=%0b v_init=%0d want busy=1 en=0 v_init=%0d",
               tag, o_busy, o_en, o_v_init, want);
    end
  endtask

  // From the LAUNCH cycle: fly for f cycles, land with distance d, return to IDLE.
  task automatic fly_phase(input int f, input logic [10:0] d, input bit hold, input string tag);
    if (hold) i_btn = 1'b1;
    if (f == 0) begin i_done = 1'b1; i_dist = d; end
    tick();
    checks++;
    if ({o_en, o_land_valid} !== 2'b10) begin
      failures++;
      $display("FAIL %s_en_rise: en=%0b lv=%0b want en=1 lv=0", tag, o_en, o_land_valid);
    end
    if (f > 0) begin
      for (int i = 1; i < f; i++) begin
        tick();
        checks++;
        if ({o_en, o_land_valid} !== 2'b10) begin
          failures++;
          $display("FAIL %s_fly%0d: en=%0b lv=%0b want en=1 lv=0", tag, i, o_en, o_land_valid);
        end
      end
      i_done = 1'b1;
      i_dist = d;
    end
    tick();
    checks++;
    if ({o_busy, o_en, o_land_valid, o_charge, o_land_dist} !== {3'b101, 11'd0, d}) begin
      failures++;
      $display("FAIL %s_land: busy=%0b en=%0b lv=%0b charge=%0d dist=%0d want 1 0 1 0 %0d",
               tag, o_busy, o_en, o_land_valid, o_charge, o_land_dist, d);
    end
    last_dist = d;
    tick();
    checks++;
    if ({o_land_valid, o_busy} !== 2'b01) begin
      failures++;
      $display("FAIL %s_lv_once: lv=%0b busy=%0b want lv=0 busy=1", tag, o_land_valid, o_busy);
    end
    i_done = 1'b0;
    if (hold) begin
      for (int i = 0; i < 5; i++) begin
        tick();
        checks++;
        if ({o_busy, o_charge} !== {1'b1, 11'd0}) begin
          failures++;
          $display("FAIL %s_land_hold%0d: busy=%0b charge=%0d want busy=1 charge=0",
                   tag, i, o_busy, o_charge);
        end
      end
      i_btn = 1'b0;
      for (int i = 0; i < 3; i++) begin
        tick();
        checks++;
        if (o_busy !== 1'b1) begin
          failures++;
          $display("FAIL %s_land_release%0d: busy=%0b want 1", tag, i, o_busy);
        end
      end
    end
    tick();
    checks++;
    if ({o_busy, o_en, o_land_dist} !== {2'b00, d}) begin
      failures++;
      $display("FAIL %s_idle: busy=%0b en=%0b dist=%0d want 0 0 %0d",
               tag, o_busy, o_en, o_land_dist, d);
    end
    tick();
    checks++;
    if (o_busy !== 1'b0) begin
      failures++;
      $display("FAIL %s_no_rejump: busy=%0b want 0", tag, o_busy);
    end
  endtask

  task automatic test_reset();
    repeat (2) tick();
    checks++;
    if ({o_en, o_v_init, o_charge, o_busy, o_land_valid, o_land_dist} !== 36'd0) begin
      failures++;
      $display("FAIL reset: en=%0b v=%0d ch=%0d busy=%0b lv=%0b dist=%0d want all 0",
               o_en, o_v_init, o_charge, o_busy, o_land_valid, o_land_dist);
    end
    #2 rst_n = 1'b1;
    i_game_run = 1'b1;
    tick();
  endtask

  task automatic test_debounce();
    int pat[6] = '{1, 1, 0, 1, 1, 0};
    i_btn = 1'b1;
    repeat (2) tick();
    i_btn = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (o_busy !== 1'b0) begin
        failures++;
        $display("FAIL db_glitch2 c%0d: busy=%0b want 0", i, o_busy);
      end
    end
    for (int i = 0; i < 6; i++) begin
      i_btn = pat[i][0];
      tick();
      checks++;
      if (o_busy !== 1'b0) begin
        failures++;
        $display("FAIL db_broken c%0d: busy=%0b want 0", i, o_busy);
      end
    end
    i_btn = 1'b0;
    repeat (3) tick();
    i_btn = 1'b1;
    repeat (3) tick();
    i_btn = 1'b0;
    tick();
    checks++;
    if ({o_busy, o_charge} !== {1'b1, 11'd16}) begin
      failures++;
      $display("FAIL db_pulse3: busy=%0b charge=%0d want busy=1 charge=16", o_busy, o_charge);
    end
    i_game_run = 1'b0;
    tick();
    i_game_run = 1'b1;
    repeat (4) tick();
    checks++;
    if ({o_busy, o_en, o_charge} !== 13'd0) begin
      failures++;
      $display("FAIL db_abort: busy=%0b en=%0b charge=%0d want 0", o_busy, o_en, o_charge);
    end
  endtask

  task automatic test_charge_launch();
    charge_phase(28, "cl");
    fly_phase(3, 11'd300, 1'b0, "cl");
  endtask

  task automatic test_saturation();
    charge_phase(301, "sat");
    fly_phase(1, 11'($urandom_range(1, 2047)), 1'b0, "sat");
  endtask

  task automatic test_abort();
    charge_phase(10, "ab");
    tick();
    i_game_run = 1'b0;
    i_done = 1'b1;
    i_dist = 11'd5;
    tick();
    checks++;
    if ({o_busy, o_en, o_land_valid, o_charge, o_land_dist} !== {3'b000, 11'd0, last_dist}) begin
      failures++;
      $display("FAIL abort: busy=%0b en=%0b lv=%0b charge=%0d dist=%0d want 0 0 0 0 %0d",
               o_busy, o_en, o_land_valid, o_charge, o_land_dist, last_dist);
    end
    i_game_run = 1'b1;
    i_done = 1'b0;
    tick();
    checks++;
    if ({o_busy, o_land_valid} !== 2'b00) begin
      failures++;
      $display("FAIL abort_idle: busy=%0b lv=%0b want 0 0", o_busy, o_land_valid);
    end
  endtask

  task automatic test_hold_through_land();
    charge_phase(6, "hold");
    fly_phase(4, 11'd777, 1'b1, "hold");
  endtask

  task automatic test_reset_mid();
    i_btn = 1'b1;
    repeat (10) tick();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({o_en, o_v_init, o_charge, o_busy, o_land_valid, o_land_dist} !== 36'd0) begin
      failures++;
      $display("FAIL reset_mid_charge: en=%0b v=%0d ch=%0d busy=%0b dist=%0d want all 0",
               o_en, o_v_init, o_charge, o_busy, o_land_dist);
    end
    last_dist = '0;
    i_btn = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (3) tick();
    charge_phase(5, "rf");
    tick();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (o_en !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_fly: en=%0b want 0", o_en);
    end
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (3) tick();
  endtask

  task automatic test_random();
    int h, f, g;
    bit hold;
    logic [10:0] d;
    for (int it = 0; it < 8; it++) begin
      h    = $urandom_range(3, 90);
      f    = $urandom_range(0, 6);
      d    = 11'($urandom_range(1, 2047));
      hold = 1'($urandom_range(0, 1));
      g    = $urandom_range(1, 2);
      i_btn = 1'b1;
      repeat (g) tick();
      i_btn = 1'b0;
      repeat (4) tick();
      checks++;
      if (o_busy !== 1'b0) begin
        failures++;
        $display("FAIL rnd%0d_glitch: busy=%0b want 0", it, o_busy);
      end
      charge_phase(h, "rnd");
      fly_phase(f, d, hold, "rnd");
    end
  endtask

  initial begin
    test_reset();
    test_debounce();
    test_charge_launch();
    test_saturation();
    test_abort();
    test_hold_through_land();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
